// File: rtl/adler32_word_feeder.sv
// Word-to-byte feeder for the Adler-32 checksum block.
// Takes 32-bit message words on a valid/ready handshake and streams them MSB-first,
// one byte per cycle. The last word of a message may carry 1..4 valid bytes. After
// each message a fixed idle gap lets the checksum block settle and present its result.
module adler32_word_feeder #(
    parameter int unsigned GAP_CYCLES = 2  // 1..15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        data_valid,
    output logic [7:0]  data,
    output logic        last_data
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    // The gap counter counts down to zero inclusive, so GAP_CYCLES-1 yields GAP_CYCLES cycles.
    localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [31:0] cur_q;
    logic [1:0]  idx_q;
    logic [1:0]  lim_q;
    logic        cur_last_q;
    logic [3:0]  gap_cnt_q;

    logic        at_lim;
    logic        accept;
    logic [1:0]  load_lim;
    logic [7:0]  cur_byte;

    // Handshake decode: ready depends only on state (and reset), never on in_valid.
    always_comb begin
        at_lim   = (idx_q == lim_q);
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:  in_ready = 1'b1;
                StSend:  in_ready = at_lim && !cur_last_q;
                default: in_ready = 1'b0;
            endcase
        end
        accept   = in_valid && in_ready;
        // in_bytes of 0 means a full word; the 2-bit wrap maps it to index 3.
        load_lim = in_last ? (in_bytes - 2'd1) : 2'd3;
    end

    // Byte selector: index 0 is the most significant byte of the word.
    always_comb begin
        cur_byte = 8'h00;
        unique case (idx_q)
            2'd0: cur_byte = cur_q[31:24];
            2'd1: cur_byte = cur_q[23:16];
            2'd2: cur_byte = cur_q[15:8];
            2'd3: cur_byte = cur_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    // Byte stream outputs, decoded purely from registered state.
    always_comb begin
        data_valid = (state_q == StSend);
        data       = data_valid ? cur_byte : 8'h00;
        last_data  = data_valid && cur_last_q && at_lim;
    end

    // Main FSM: word load, byte stepping and the post-message gap.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_q      <= 32'h0000_0000;
            idx_q      <= 2'd0;
            lim_q      <= 2'd0;
            cur_last_q <= 1'b0;
            gap_cnt_q  <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cur_q      <= in_data;
                        lim_q      <= load_lim;
                        cur_last_q <= in_last;
                        idx_q      <= 2'd0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (!at_lim) begin
                        idx_q <= idx_q + 2'd1;
                    end else if (cur_last_q) begin
                        gap_cnt_q <= GapLoad;
                        state_q   <= StGap;
                    end else if (accept) begin
                        // Next word of the same message follows without a bubble.
                        cur_q      <= in_data;
                        lim_q      <= load_lim;
                        cur_last_q <= in_last;
                        idx_q      <= 2'd0;
                    end else begin
                        // Upstream underflow mid-message: pause until the next word.
                        state_q <= StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adler32_word_feeder.sv
// Directed bench for adler32_word_feeder: a scoreboard queue holds the bytes each accepted
// word must produce, a negedge monitor pops and compares them, and a reference Adler-32
// runs over the observed byte stream.
module tb_adler32_word_feeder;

    localparam int unsigned GAP = 2;

    logic        clock;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        data_valid;
    logic [7:0]  data;
    logic        last_data;

    adler32_word_feeder #(
        .GAP_CYCLES(GAP)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .data_valid(data_valid),
        .data      (data),
        .last_data (last_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Monitor state
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          msg_start = 1'b1;
    int          start_delta = 0;
    int          start_gap_len = 0;
    bit          after_last = 1'b0;
    int          low_run = 0;
    int          gap_len = 0;
    int          run = 0;
    int          msg_run = 0;
    int          bytes = 0;
    int          msg_len = 0;
    int          idle_run = 0;
    int          mid_idle = 0;
    int          ad_a = 1;
    int          ad_b = 0;
    logic [31:0] adler_res = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: offers one word, records its bytes once the handshake lands.
    task automatic send_word(input logic [31:0] w, input logic l, input logic [1:0] nb);
        int   waited;
        int   n;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = l;
        in_bytes = nb;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            n = l ? ((nb == 2'd0) ? 4 : int'(nb)) : 4;
            for (int k = 0; k < n; k++) begin
                e.b = w[31-8*k -: 8];
                e.l = l && (k == n - 1);
                exp_q.push_back(e);
            end
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Waits (bounded) until every expected byte has been observed; returns at posedge+1.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Output monitor: scoreboard compare, idle-value checks, timing and Adler-32 bookkeeping.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            cyc++;
            if (after_last) begin
                if (!in_ready) begin
                    low_run++;
                end else begin
                    gap_len    = low_run;
                    after_last = 1'b0;
                end
            end
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_byte_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", {24'b0, data}, {24'b0, e.b});
                    chk("last_data", {31'b0, last_data}, {31'b0, e.l});
                end
                if (msg_start) begin
                    start_delta   = cyc - last_cyc;
                    start_gap_len = gap_len;
                    mid_idle      = 0;
                    msg_start     = 1'b0;
                end else if (idle_run > mid_idle) begin
                    mid_idle = idle_run;
                end
                idle_run = 0;
                run++;
                bytes++;
                ad_a = (ad_a + int'(data)) % 65521;
                ad_b = (ad_b + ad_a) % 65521;
                if (last_data) begin
                    last_cyc   = cyc;
                    msg_start  = 1'b1;
                    msg_run    = run;
                    msg_len    = bytes;
                    bytes      = 0;
                    adler_res  = {ad_b[15:0], ad_a[15:0]};
                    ad_a       = 1;
                    ad_b       = 0;
                    after_last = 1'b1;
                    low_run    = 0;
                end
            end else begin
                run = 0;
                idle_run++;
                chk("idle_data", {24'b0, data}, 32'd0);
                chk("idle_last", {31'b0, last_data}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d expected to finish", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 edges with in_valid high.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_last  = 1'b0;
        in_bytes = 2'd0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
            chk("rst_data_valid", {31'b0, data_valid}, 32'd0);
            chk("rst_data", {24'b0, data}, 32'd0);
            chk("rst_last_data", {31'b0, last_data}, 32'd0);
        end
        @(posedge clock);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // "Wikipedia" as three back-to-back words.
        send_word(32'h5769_6B69, 1'b0, 2'd0);
        send_word(32'h7065_6469, 1'b0, 2'd0);
        send_word(32'h6100_0000, 1'b1, 2'd1);
        drain("wiki");
        chk("wiki_run", msg_run, 32'd9);
        chk("wiki_len", msg_len, 32'd9);
        chk("wiki_adler", adler_res, 32'h11E6_0398);

        // Last-word widths 1, 2, 3 and 0 (= 4).
        for (int i = 0; i < 4; i++) begin
            logic [1:0] nb;
            nb = 2'(i + 1);
            send_word(32'hA1B2_C3D4, 1'b1, nb);
            drain("width");
            chk("width_len", msg_len, (nb == 2'd0) ? 32'd4 : {30'b0, nb});
        end

        // Two messages offered back to back: gap length and restart latency.
        send_word(32'hDEAD_BEEF, 1'b1, 2'd2);
        send_word(32'h0BAD_F00D, 1'b1, 2'd0);
        drain("b2b");
        chk("b2b_gap_len", start_gap_len, GAP);
        chk("b2b_start_delta", start_delta, GAP + 2);
        chk("b2b_len", msg_len, 32'd4);

        // Upstream stall of 3 cycles between two words of one message.
        send_word(32'h0102_0304, 1'b0, 2'd0);
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        send_word(32'h0506_0708, 1'b1, 2'd0);
        drain("stall");
        chk("stall_idle", mid_idle, 32'd3);
        chk("stall_len", msg_len, 32'd8);

        // Reset while byte 2 of a word is on the bus.
        send_word(32'h1122_3344, 1'b0, 2'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("mid_byte2", {24'b0, data}, 32'h33);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ad_a      = 1;
        ad_b      = 0;
        bytes     = 0;
        msg_start = 1'b1;
        @(negedge clock);
        chk("mid_post_valid", {31'b0, data_valid}, 32'd0);
        chk("mid_post_data", {24'b0, data}, 32'd0);
        chk("mid_post_last", {31'b0, last_data}, 32'd0);
        chk("mid_post_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        send_word(32'hCAFE_F00D, 1'b1, 2'd3);
        drain("after_rst");
        chk("after_rst_len", msg_len, 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
